// File: rtl/fetch_pc.sv
// Fetch program counter and single-entry instruction buffer, one request in flight.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky misaligned-redirect flag.
module fetch_pc #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic        capture;
  logic        redirect_taken;
  logic [63:0] target;

  assign target         = {redirect_pc[63:2], 2'b00};
  assign redirect_taken = redirect_valid && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        inst    <= iresp_data;
        inst_pc <= pc;
      end
    end
  end

  // Redirect wins over every handshake; DRAIN absorbs the response of a stale request.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          state_nxt = ireq_ready ? DRAIN : REQ;
        end else if (ireq_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          state_nxt = iresp_valid ? REQ : DRAIN;
        end else if (iresp_valid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = target;
          state_nxt = REQ;
        end else if (inst_ready) begin
          pc_nxt    = pc + 64'd4;
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_nxt = target;
        if (iresp_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ireq_valid = (state == REQ);
  assign inst_valid = (state == HOLD);
  assign ireq_addr  = pc;

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (redirect_taken && (redirect_pc[1:0] != 2'b00)) err_q <= 1'b1;
  end
  assign misalign_err = err_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect_taken ^ (^redirect_pc[1:0]);
  assign misalign_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Randomized and directed bench for fetch_pc against a transaction-level model.
module tb_fetch_pc;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready = 1'b0;
  logic        iresp_valid = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        misalign_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  fetch_pc #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Model: a fetch engine that has started, may have one request in flight
  // (possibly made stale by a redirect) and may hold one buffered instruction.
  logic        m_started, m_outst, m_stale, m_have, m_err;
  logic [63:0] m_pc, m_inst_pc;
  logic [31:0] m_inst;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_outst = 0; m_stale = 0; m_have = 0; m_err = 0;
    m_pc = RESET_PC; m_inst = '0; m_inst_pc = '0;
  endtask

  function automatic logic exp_ireq_valid();
    return m_started && !m_outst && !m_have;
  endfunction

  task automatic check_outputs();
    chk("ireq_valid", 64'(ireq_valid), 64'(exp_ireq_valid()));
    chk("ireq_addr", ireq_addr, m_pc);
    chk("inst_valid", 64'(inst_valid), 64'(m_have));
    chk("inst", 64'(inst), 64'(m_inst));
    chk("inst_pc", inst_pc, m_inst_pc);
    chk("misalign_err", 64'(misalign_err), 64'(m_err));
  endtask

  task automatic model_edge();
    logic fire_req, fire_resp, consume;
    if (!m_started) begin
      m_started = 1;
      return;
    end
    fire_req  = exp_ireq_valid() && ireq_ready;
    fire_resp = m_outst && iresp_valid;
    consume   = m_have && inst_ready;
    if (redirect_valid) begin
      m_pc   = redirect_pc & ~64'd3;
      m_err  = m_err | (ERR_EN && (redirect_pc % 4 != 0));
      m_have = 0;
      if (fire_req) begin m_outst = 1; m_stale = 1; end
      else if (fire_resp) m_outst = 0;
      else if (m_outst) m_stale = 1;
    end else begin
      if (fire_req) begin m_outst = 1; m_stale = 0; end
      if (fire_resp) begin
        m_outst = 0;
        if (!m_stale) begin m_have = 1; m_inst = iresp_data; m_inst_pc = m_pc; end
      end
      if (consume) begin m_have = 0; m_pc = m_pc + 64'd4; end
    end
  endtask

  // Called at a falling edge: check, drive, advance one rising edge, return at next falling edge.
  task automatic step(input logic rv, input logic [63:0] rpc, input logic rdy,
                      input logic rspv, input logic [31:0] d, input logic ir);
    check_outputs();
    redirect_valid = rv; redirect_pc = rpc; ireq_ready = rdy;
    iresp_valid = rspv; iresp_data = d; inst_ready = ir;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("reset_addr", ireq_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    // Redirect and a late response in IDLE must both be ignored.
    step(1'b1, 64'h1234_5678_9ABC_DEF1, 1'b1, 1'b1, $urandom, 1'b1);
  endtask

  logic [63:0] seen[$];
  int          seen_cyc[$];
  logic [63:0] exp_seq[3];
  logic [63:0] rpc;

  initial begin
    exp_seq[0] = 64'h8000_0000; exp_seq[1] = 64'h8000_0004; exp_seq[2] = 64'h8000_0008;
    @(negedge clk);
    do_reset();

    // Straight-line fetch with an always-ready, one-cycle memory.
    for (int i = 0; i < 9; i++) begin
      if (ireq_valid) begin seen.push_back(ireq_addr); seen_cyc.push_back(cyc); end
      step(1'b0, '0, 1'b1, 1'b1, $urandom, 1'b1);
    end
    chk("seq_len", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("seq_addr", seen[i], exp_seq[i]);
    for (int i = 1; i < 3 && i < seen.size(); i++) chk("seq_period", 64'(seen_cyc[i] - seen_cyc[i-1]), 64'd3);

    // Redirect in WAIT without response; response two cycles later is discarded.
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 64'h8000_1000, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("drain_inst_valid", 64'(inst_valid), 64'd0);
    step(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("drain_inst_valid2", 64'(inst_valid), 64'd0);
    chk("drain_next_addr", ireq_addr, 64'h8000_1000);
    chk("drain_next_valid", 64'(ireq_valid), 64'd1);

    // Redirect in HOLD together with inst_ready.
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
    chk("hold_valid", 64'(inst_valid), 64'd1);
    step(1'b1, 64'h8000_0200, 1'b0, 1'b0, '0, 1'b1);
    chk("hold_redirect_addr", ireq_addr, 64'h8000_0200);
    chk("hold_redirect_drop", 64'(inst_valid), 64'd0);

    // Redirect while the request is stalled.
    do_reset();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 64'h8000_0040, 1'b0, 1'b0, '0, 1'b0);
    chk("stall_addr", ireq_addr, 64'h8000_0040);
    chk("stall_valid", 64'(ireq_valid), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("stall_valid_end", 64'(ireq_valid), 64'd1);

    // Top-of-address-space wrap.
    do_reset();
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 32'h1111_2222, 1'b0);
    chk("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("wrap_addr", ireq_addr, 64'h0);

    // Misaligned redirect.
    do_reset();
    step(1'b1, 64'h8000_0006, 1'b0, 1'b0, '0, 1'b0);
    chk("misalign_addr", ireq_addr, 64'h8000_0004);
    chk("misalign_flag", 64'(misalign_err), 64'(ERR_EN));

    // Reset in the middle of an outstanding request.
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    do_reset();

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      case ($urandom_range(0, 3))
        0: rpc = {$urandom, $urandom};
        1: rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: rpc = 64'h8000_0000 | 64'($urandom_range(0, 4095));
      endcase
      step($urandom_range(0, 7) == 0, rpc, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0);
      if (ireq_valid && inst_valid) chk("exclusive_valid", 64'd1, 64'd0);
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
- REQ-001: Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
- REQ-002: clk  in  1  sole clock; all state updates on the rising edge.
- REQ-003: rst_n  in  1  asynchronous, active-low reset.
- REQ-004: redirect_valid  in  1  the branch unit requests a control-flow change this cycle.
- REQ-005: redirect_pc  in  64  redirect target; sampled only when redirect_valid=1.
- REQ-006: ireq_valid  out  1  instruction-memory request valid.
- REQ-007: ireq_addr  out  64  request address; equals the internal pc register.
- REQ-008: ireq_ready  in  1  memory accepts the request when ireq_valid && ireq_ready.
- REQ-009: iresp_valid  in  1  response for the single outstanding request.
- REQ-010: iresp_data  in  32  instruction word.
- REQ-011: inst_valid  out  1  buffered instruction offered to decode.
- REQ-012: inst  out  32  buffered instruction word.
- REQ-013: inst_pc  out  64  address of inst.
- REQ-014: inst_ready  in  1  decode consumes inst when inst_valid && inst_ready.
- REQ-015: misalign_err  out  1  sticky misaligned-redirect flag (see Configuration).

Function
- REQ-016: The FSM SHALL use states IDLE, REQ, WAIT, HOLD and DRAIN, with at most one memory request outstanding.
- REQ-017: IDLE -> REQ unconditionally on the first edge after reset release.
- REQ-018: REQ: ireq_valid=1. Handshake -> WAIT. No handshake -> hold REQ with ireq_addr stable.
- REQ-019: WAIT: iresp_valid -> capture iresp_data into inst and pc into inst_pc, go to HOLD. inst_valid=1 from the next cycle.
- REQ-020: HOLD: inst_valid=1. On handshake: pc <= pc+4 (64-bit wrap, carry dropped), go to REQ. Otherwise hold inst and inst_pc stable.
- REQ-021: Throughput is one instruction per 3 cycles minimum (REQ, WAIT, HOLD), with a zero-wait memory.
- REQ-022: Redirect has priority over every other event in every state except IDLE. pc <= aligned target, where aligned target = {redirect_pc[63:2],2'b00}.
- REQ-023: Redirect in REQ without ireq_ready: stay in REQ. ireq_addr shows the new pc next cycle.
- REQ-024: Redirect in REQ with ireq_ready in the same cycle: the accepted request is stale, go to DRAIN.
- REQ-025: Redirect in WAIT with iresp_valid in the same cycle: discard the response, go to REQ.
- REQ-026: Redirect in WAIT without iresp_valid: go to DRAIN.
- REQ-027: DRAIN: ireq_valid=0 and inst_valid=0. iresp_valid -> discard it, go to REQ. A further redirect updates pc and stays in DRAIN (or goes to REQ if iresp_valid is in the same cycle).
- REQ-028: Redirect in HOLD, including with inst_ready=1: the buffered instruction is dropped and pc is not incremented.
  - inst_valid=0 next cycle.
  - Go to REQ.
- REQ-029: Redirect in IDLE is ignored.
- REQ-030: ireq_valid and inst_valid are never high in the same cycle.

Reset
- REQ-031: On rst_n=0, asynchronously:
  - state=IDLE, pc=RESET_PC
  - ireq_valid=0, inst_valid=0
  - inst=0, inst_pc=0, misalign_err=0
- REQ-032: Reset asserted mid-request abandons the outstanding request. iresp_valid arriving in IDLE is ignored.

Configuration
- REQ-033: With FETCH_MISALIGN_CHK_EN defined, misalign_err is set on any redirect with redirect_pc[1:0]!=0 and cleared only by reset. pc still takes the aligned target.
- REQ-034: With FETCH_MISALIGN_CHK_EN undefined, misalign_err is tied to 0 and low target bits are cleared silently.

Verification
- REQ-035: Release reset, memory always ready, 1-cycle response -> ireq_addr sequence 0x80000000, 0x80000004, 0x80000008. Each inst_pc matches the request, one instruction every 3 cycles.
- REQ-036: Redirect to 0x80001000 in WAIT with no response; response arrives 2 cycles later -> response discarded, inst_valid stays 0, next ireq_addr=0x80001000.
- REQ-037: HOLD with inst_ready=1 and redirect to 0x80000200 in the same cycle -> no consume, pc=0x80000200, not 0x80000004.
- REQ-038: ireq_ready low for 4 cycles, redirect to 0x80000040 in cycle 2 -> ireq_addr changes to 0x80000040 in cycle 3, ireq_valid never drops.
- REQ-039: pc=0xFFFFFFFFFFFFFFFC consumed -> next ireq_addr=0x0.
- REQ-040: Redirect to 0x80000006 -> ireq_addr=0x80000004. misalign_err=1 with FETCH_MISALIGN_CHK_EN, 0 without.
